// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, state encoding common to both link ends, parity helper.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // IDLE..STOP match the transmitter's encoding; BREAK exists only on the receive side.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_STOP   = 3'b100,
    ST_BREAK  = 3'b101
  } uart_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_dut_if.sv
// Receiver-side link bundle: serial input plus the received-byte result bus.
interface uart_rx_dut_if;
  import uart_pkg::*;

  logic                 rx1;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx1,
    output data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    output rx1,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the idle-high serial line; resets to 1 so reset never looks like a start bit.
// Latency 2 cycles, no backpressure.
module uart_sync2 (
  input  logic clk_uart,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_dut.sv
// 8E1 UART receiver: mid-bit sampling, one-cycle data_valid with held byte and error flags.
// Strobe 10.5 bit periods + 2 cycles after the start edge; no backpressure, every completed frame strobes.
module uart_rx_dut
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int CNT_W      = 5
) (
  input  logic          clk_uart,
  input  logic          rst,
  uart_rx_dut_if.master link
);

  localparam int BIT_W = $clog2(DATA_BITS);

  uart_state_t          state, state_nx;
  logic [CNT_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_rx;
  logic                 rx_s;
  logic                 tick_mid, tick_last;
  logic                 sample_bit, sample_par, frame_done;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q;

  uart_sync2 u_sync (
    .clk_uart (clk_uart),
    .rst      (rst),
    .d        (link.rx1),
    .q        (rx_s)
  );

  assign tick_mid  = (tick_cnt == CNT_W'(OVERSAMPLE/2 - 1));
  assign tick_last = (tick_cnt == CNT_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    sample_bit = 1'b0;
    sample_par = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE:   if (!rx_s) state_nx = ST_START;
      ST_START:  if (tick_mid) state_nx = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick_last) begin
                   sample_bit = 1'b1;
                   if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_nx = ST_PARITY;
                 end
      ST_PARITY: if (tick_last) begin
                   sample_par = 1'b1;
                   state_nx   = ST_STOP;
                 end
      // Leaving STOP at mid-bit gives half a bit of slack for a back-to-back start edge.
      ST_STOP:   if (tick_last) begin
                   frame_done = 1'b1;
                   state_nx   = rx_s ? ST_IDLE : ST_BREAK;
                 end
      ST_BREAK:  if (rx_s) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_rx   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q <= frame_done;

      if (state_nx != state || sample_bit)
        tick_cnt <= '0;
      else if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
        tick_cnt <= tick_cnt + CNT_W'(1);

      if (state == ST_START && state_nx == ST_DATA)
        bit_cnt <= '0;
      else if (sample_bit)
        bit_cnt <= bit_cnt + BIT_W'(1);

      if (sample_bit) shift[bit_cnt] <= rx_s;
      if (sample_par) par_rx <= rx_s;

      if (frame_done) begin
        data_q <= shift;
        perr_q <= (par_rx != even_parity(shift));
        ferr_q <= !rx_s;
      end
    end
  end

  assign link.data_out   = data_q;
  assign link.data_valid = valid_q;
  assign link.parity_err = perr_q;
  assign link.frame_err  = ferr_q;
  assign link.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_dut.sv
// Directed and randomized 8E1 frames against a frame-level reference model of the receiver.
module tb_uart_rx_dut;
  import uart_pkg::*;

  localparam int OS         = 16;
  localparam int FRAME      = 11 * OS;
  // mid stop bit (10.5 bit periods) plus the two synchronizer cycles
  localparam int STROBE_LAT = 10 * OS + OS / 2 + 2;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ev_t;

  logic clk_uart = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  evq[$];

  uart_rx_dut_if link ();

  uart_rx_dut #(.OVERSAMPLE(OS), .CNT_W(5)) dut (
    .clk_uart (clk_uart),
    .rst      (rst),
    .link     (link)
  );

  always #5 clk_uart = ~clk_uart;
  always @(posedge clk_uart) cyc <= cyc + 1;

  always @(negedge clk_uart)
    if (link.data_valid === 1'b1)
      evq.push_back('{cyc, link.data_out, link.parity_err, link.frame_err});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (observed cycle=%0d, required < %0d)", cyc, 200000);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    link.rx1 = b;
    repeat (n) @(negedge clk_uart);
  endtask

  // Called on a negedge; t0 is the first clock edge that sees the start bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, output int t0);
    t0 = cyc + 1;
    send_bit(1'b0, OS);
    for (int i = 0; i < 8; i++) send_bit(d[i], OS);
    send_bit(par, OS);
    send_bit(stp, OS);
  endtask

  task automatic expect_frame(input string tag, input int t0, input logic [7:0] d,
                              input logic pe, input logic fe);
    ev_t e;
    chk({tag, " strobes"}, evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({tag, " time"}, e.t - t0, STROBE_LAT);
      chk({tag, " data"}, e.d, d);
      chk({tag, " perr"}, e.pe, pe);
      chk({tag, " ferr"}, e.fe, fe);
    end
    evq.delete();
  endtask

  function automatic logic model_par(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  int         t0, t1, h, gap, hold;
  ev_t        e0, e1;
  logic [7:0] rd;
  logic       rpar, rstop;

  initial begin
    rst      = 1'b1;
    link.rx1 = 1'b1;
    repeat (3) @(negedge clk_uart);
    chk("reset data", link.data_out, 8'h00);
    chk("reset valid", link.data_valid, 1'b0);
    chk("reset perr", link.parity_err, 1'b0);
    chk("reset ferr", link.frame_err, 1'b0);
    chk("reset busy", link.busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk_uart);

    // clean frame
    send_frame(8'hA5, model_par(8'hA5), 1'b1, t0);
    expect_frame("a5", t0, 8'hA5, 1'b0, 1'b0);
    chk("a5 busy after", link.busy, 1'b0);
    chk("a5 held data", link.data_out, 8'hA5);
    chk("a5 valid low", link.data_valid, 1'b0);
    repeat (4) @(negedge clk_uart);

    // wrong parity bit
    send_frame(8'h3C, ~model_par(8'h3C), 1'b1, t0);
    expect_frame("3c", t0, 8'h3C, 1'b1, 1'b0);
    repeat (4) @(negedge clk_uart);

    // stop bit low, line held low three bit periods in total
    send_frame(8'h01, 1'b1, 1'b0, t0);
    send_bit(1'b0, 2 * OS);
    chk("break busy", link.busy, 1'b1);
    expect_frame("break", t0, 8'h01, 1'b0, 1'b1);
    link.rx1 = 1'b1;
    h = cyc + 1;
    @(negedge clk_uart);
    @(negedge clk_uart);
    chk("break busy h+1", link.busy, 1'b1);
    @(negedge clk_uart);
    chk("break idle h+2", link.busy, 1'b0);
    chk("break idle time", cyc - h, 2);
    repeat (4) @(negedge clk_uart);

    // 4-cycle glitch must be rejected at mid start bit
    send_bit(1'b0, 4);
    link.rx1 = 1'b1;
    chk("glitch busy", link.busy, 1'b1);
    repeat (12) @(negedge clk_uart);
    chk("glitch busy end", link.busy, 1'b0);
    repeat (30) @(negedge clk_uart);
    chk("glitch strobes", evq.size(), 0);
    chk("glitch data", link.data_out, 8'h01);
    chk("glitch ferr", link.frame_err, 1'b1);
    chk("glitch perr", link.parity_err, 1'b0);
    evq.delete();

    // back-to-back frames, no idle gap
    send_frame(8'h55, model_par(8'h55), 1'b1, t0);
    send_frame(8'hAA, model_par(8'hAA), 1'b1, t1);
    chk("b2b strobes", evq.size(), 2);
    if (evq.size() == 2) begin
      e0 = evq.pop_front();
      e1 = evq.pop_front();
      chk("b2b first time", e0.t - t0, STROBE_LAT);
      chk("b2b spacing", e1.t - e0.t, FRAME);
      chk("b2b data0", e0.d, 8'h55);
      chk("b2b data1", e1.d, 8'hAA);
      chk("b2b errs", {e0.pe, e0.fe, e1.pe, e1.fe}, 4'b0000);
    end
    evq.delete();
    repeat (4) @(negedge clk_uart);

    // reset in the middle of data bit 4 of 0xFF
    send_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) send_bit(1'b1, OS);
    send_bit(1'b1, OS / 2);
    rst = 1'b1;
    @(negedge clk_uart);
    chk("midrst data", link.data_out, 8'h00);
    chk("midrst busy", link.busy, 1'b0);
    chk("midrst flags", {link.data_valid, link.parity_err, link.frame_err}, 3'b000);
    @(negedge clk_uart);
    rst = 1'b0;
    repeat (FRAME) @(negedge clk_uart);
    chk("midrst strobes", evq.size(), 0);
    chk("midrst data held", link.data_out, 8'h00);
    evq.delete();
    send_frame(8'h0F, model_par(8'h0F), 1'b1, t0);
    expect_frame("0f", t0, 8'h0F, 1'b0, 1'b0);

    // randomized frames: random byte, parity sometimes flipped, occasional low stop bit
    for (int n = 0; n < 12; n++) begin
      rd    = 8'($urandom);
      rpar  = model_par(rd) ^ ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 3) != 0);
      gap   = $urandom_range(0, 20);
      send_frame(rd, rpar, rstop, t0);
      if (!rstop) begin
        hold = $urandom_range(0, 2 * OS);
        send_bit(1'b0, hold);
        gap = gap + 3;
      end
      expect_frame("rand", t0, rd, rpar != model_par(rd), !rstop);
      send_bit(1'b1, gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
